mem_port_ctrl: RTL
==================

Name: mem_port_ctrl

Overview:
- Memory-side stage directly downstream of the matmul engine.
- Terminates matmul's request port: mem_req, mem_write, mem_addr, mem_wdata, mem_rdata_vld, mem_rdata.
- Drives a single-port synchronous SRAM.
- Returns read data with a fixed, parameterised latency.
- Contains a hardware fill engine that initialises an address range before a matmul run, replacing bench-side memory init.

Parameters:
- MEM_AW, 16: address width.
- MEM_DW, 32: data width.
- RD_LAT, 2: request-to-mem_rdata_vld latency in cycles; legal range 1..4.
- INIT_VAL, 0: value written by the fill engine, MEM_DW bits.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  in  1  one-cycle request strobe from matmul.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  in  MEM_AW  request address.
- mem_wdata  in  MEM_DW  write data.
- mem_rdata_vld  out  1  read data valid, one cycle per read.
- mem_rdata  out  MEM_DW  read data.
- init_go  in  1  start fill; sampled only in IDLE.
- init_base  in  MEM_AW  first fill address; captured on init_go.
- init_len  in  MEM_AW  number of words to fill; captured on init_go.
- init_busy  out  1  fill engine active.
- init_done  out  1  one-cycle pulse when the fill completes.
- err_drop  out  1  sticky flag: a matmul request was dropped.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  MEM_AW  SRAM address.
- sram_wdata  out  MEM_DW  SRAM write data.
- sram_rdata  in  MEM_DW  SRAM read data; valid the cycle after sram_ce=1, sram_we=0.

Behaviour:
- Reset values: mem_rdata_vld=0, mem_rdata=0, init_busy=0, init_done=0, err_drop=0, sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0. FSM=IDLE; read-valid pipeline cleared.
- FSM states: IDLE, FILL, DONE.
- IDLE, normal path:
  - SRAM port is a combinational pass-through: sram_ce=mem_req, sram_we=mem_write, sram_addr=mem_addr, sram_wdata=mem_wdata.
  - A write completes at that edge; no response is returned.
- Read latency:
  - A read accepted in cycle T produces mem_rdata_vld=1 in cycle T+RD_LAT, with the SRAM data for that address.
  - RD_LAT=1: mem_rdata is the unregistered sram_rdata, gated by a 1-bit valid flop.
  - RD_LAT>1: sram_rdata passes through RD_LAT-1 data/valid register stages.
  - Back-to-back reads every cycle are supported: full throughput, in order.
  - mem_rdata holds its last value while mem_rdata_vld=0.
- IDLE->FILL on init_go with init_len!=0:
  - Capture init_base and init_len.
  - Each FILL cycle: sram_ce=1, sram_we=1, sram_wdata=INIT_VAL, address = base + count.
  - Address wraps modulo 2^MEM_AW.
  - After init_len writes: FILL->DONE.
- IDLE->DONE on init_go with init_len=0; no writes occur.
- DONE: init_done=1 for one cycle, then ->IDLE.
- init_busy=1 in FILL and DONE.
- init_go in FILL or DONE: ignored.
- mem_req while init_busy=1:
  - Request dropped; no SRAM access and no mem_rdata_vld.
  - err_drop set; it clears only on rst.
- mem_req and init_go in the same IDLE cycle: the request is served that cycle; the first fill write occurs in the next cycle.
- Reads issued before FILL still complete at their scheduled T+RD_LAT, even while FILL is active.
- rst mid-operation: FSM returns to IDLE, the fill is abandoned, and in-flight reads are discarded (no vld is produced).

Decomposition:
- Shared package mem_pkg holds:
  - state enum for IDLE/FILL/DONE;
  - RD_LAT_MAX=4 constant;
  - common MEM_AW/MEM_DW default constants, shared with matmul.
- One natural sub-module, rd_lat_pipe: parameterised valid/data delay line of depth RD_LAT-1.

Test Plan:
- Write/read-back, RD_LAT=2:
  - Stimulus: write 0xDEADBEEF @0x0100, then read 0x0100.
  - Required: mem_rdata_vld exactly 2 cycles after the read strobe, with mem_rdata=0xDEADBEEF.
- Streaming reads:
  - Stimulus: reads of 0x0200..0x0207 on consecutive cycles after preloading with address values.
  - Required: 8 consecutive vld cycles returning 0x200..0x207 in order; repeat with RD_LAT=1 and RD_LAT=4.
- Fill:
  - Stimulus: preload 0x0300..0x0330 with nonzero data; init_base=0x0300, init_len=0x30, init_go.
  - Required: init_busy high for 49 cycles (48 FILL + 1 DONE); init_done pulses once; reading 0x0300..0x032F returns 0; 0x0330 is unchanged.
- Wrap and zero length:
  - Stimulus: init_base=0xFFFE, init_len=4.
  - Required: writes hit 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - Stimulus: init_len=0.
  - Required: no sram_ce, and init_done one cycle after init_go.
- Drop and collision:
  - Stimulus: mem_req during FILL.
  - Required: no SRAM read, no vld, err_drop=1 until rst.
  - Stimulus: mem_req together with init_go in IDLE.
  - Required: the request is served and the fill starts the next cycle.
- Reset mid-op:
  - Stimulus: assert rst 3 cycles into a 16-word fill while a read is in flight.
  - Required: all outputs go to reset values immediately (asynchronously), and no stale vld appears after rst is released.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port controller and its neighbours in the matmul datapath.
package mem_pkg;

    localparam int MEM_AW_DEF = 16;
    localparam int MEM_DW_DEF = 32;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_port_ctrl_rd_lat_pipe.sv
// Valid/data delay line placed behind the SRAM read port; data stages only load on valid,
// so the output word holds its last value between responses.
module rd_lat_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int DW    = MEM_DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    output logic [DW-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // Zero-depth: live SRAM data while valid, otherwise the last returned word.
            logic [DW-1:0] hold_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    hold_q <= '0;
                end else if (vld_i) begin
                    hold_q <= data_i;
                end
            end

            assign vld_o  = vld_i;
            assign data_o = vld_i ? data_i : hold_q;
        end else begin : g_stages
            logic [DEPTH-1:0] vld_q;
            logic [DW-1:0]    data_q [DEPTH];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= vld_i;
                    if (vld_i) begin
                        data_q[0] <= data_i;
                    end
                    for (int i = 1; i < DEPTH; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) begin
                            data_q[i] <= data_q[i-1];
                        end
                    end
                end
            end

            assign vld_o  = vld_q[DEPTH-1];
            assign data_o = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mem_port_ctrl.sv
// Memory-side stage behind the matmul engine: passes requests to a single-port SRAM,
// returns reads at a fixed latency and runs a hardware fill of an address range.
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int                MEM_AW   = MEM_AW_DEF,
    parameter int                MEM_DW   = MEM_DW_DEF,
    parameter int                RD_LAT   = 2,
    parameter logic [MEM_DW-1:0] INIT_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_i,
    input  logic              mem_write_i,
    input  logic [MEM_AW-1:0] mem_addr_i,
    input  logic [MEM_DW-1:0] mem_wdata_i,
    output logic              mem_rdata_vld_o,
    output logic [MEM_DW-1:0] mem_rdata_o,
    input  logic              init_go_i,
    input  logic [MEM_AW-1:0] init_base_i,
    input  logic [MEM_AW-1:0] init_len_i,
    output logic              init_busy_o,
    output logic              init_done_o,
    output logic              err_drop_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [MEM_AW-1:0] sram_addr_o,
    output logic [MEM_DW-1:0] sram_wdata_o,
    input  logic [MEM_DW-1:0] sram_rdata_i
);

    state_e            state_q;
    logic [MEM_AW-1:0] base_q;
    logic [MEM_AW-1:0] len_q;
    logic [MEM_AW-1:0] cnt_q;
    logic              err_drop_q;
    logic              rd_vld_d;
    logic              rd_vld_q;

    // Any request arriving outside IDLE is dropped and latched as an error until reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            err_drop_q <= 1'b0;
        end else begin
            if (mem_req_i && (state_q != ST_IDLE)) begin
                err_drop_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (init_go_i) begin
                        base_q  <= init_base_i;
                        len_q   <= init_len_i;
                        cnt_q   <= '0;
                        state_q <= (init_len_i == '0) ? ST_DONE : ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt_q <= cnt_q + MEM_AW'(1);
                    if (cnt_q == len_q - MEM_AW'(1)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sram_ce_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    sram_ce_o    = mem_req_i;
                    sram_we_o    = mem_write_i;
                    sram_addr_o  = mem_addr_i;
                    sram_wdata_o = mem_wdata_i;
                end
                ST_FILL: begin
                    sram_ce_o    = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = base_q + cnt_q;
                    sram_wdata_o = INIT_VAL;
                end
                default: ;
            endcase
        end
    end

    // First latency stage: marks the cycle in which sram_rdata carries an accepted read.
    assign rd_vld_d = (state_q == ST_IDLE) && mem_req_i && !mem_write_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
    end

    rd_lat_pipe #(
        .DEPTH (RD_LAT - 1),
        .DW    (MEM_DW)
    ) u_rd_lat_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .vld_i  (rd_vld_q),
        .data_i (sram_rdata_i),
        .vld_o  (mem_rdata_vld_o),
        .data_o (mem_rdata_o)
    );

    assign init_busy_o = (state_q != ST_IDLE);
    assign init_done_o = (state_q == ST_DONE);
    assign err_drop_o  = err_drop_q;

endmodule
